// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples BCK/LRCK/SDATA in the clk domain and emits {left, right} pairs on valid/ready.
// Optional BCK watchdog (sticky clock_lost) is built when I2S_RX_BCK_TIMEOUT_EN is defined.
module i2s_receiver #(
  parameter int SAMPLE_BITS    = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       bck,
  input  logic                       lrck,
  input  logic                       sdata,
  output logic [2*SAMPLE_BITS-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  input  logic                       clear_status,
  output logic                       clock_lost
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic                     bck_s1, bck_s2, bck_h;
  logic                     lrck_s1, lrck_s2;
  logic                     sdata_s1, sdata_s2;
  logic                     lrck_prev;
  logic [5:0]               bit_count;
  logic [5:0]               new_count;
  logic [SAMPLE_BITS-1:0]   bit_mask;
  logic [SAMPLE_BITS-1:0]   left_sr, right_sr, left_word;
  logic [2*SAMPLE_BITS-1:0] pair_word;
  logic                     pair_pending;
  logic [1:0]               state;
  logic                     bit_event, frame_edge, abort, timeout_hit, load_ok;

  // lrck and sdata are used straight from the second stage so they line up with the bck edge;
  // only bck needs the extra history stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bck_s1   <= 1'b0;
      bck_s2   <= 1'b0;
      bck_h    <= 1'b0;
      lrck_s1  <= 1'b0;
      lrck_s2  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      bck_s1   <= bck;
      bck_s2   <= bck_s1;
      bck_h    <= bck_s2;
      lrck_s1  <= lrck;
      lrck_s2  <= lrck_s1;
      sdata_s1 <= sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  assign bit_event  = bck_s2 & ~bck_h;
  assign frame_edge = bit_event & (lrck_s2 != lrck_prev);
  assign abort      = ~enable | timeout_hit;

  always_comb begin
    if (frame_edge) begin
      new_count = 6'd0;
    end else if (bit_count == 6'd63) begin
      new_count = 6'd63;
    end else begin
      new_count = bit_count + 6'd1;
    end
  end

  // Bit n of the slot lands at position SAMPLE_BITS-n, so a short slot ends up left-justified.
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (new_count == 6'(SAMPLE_BITS - i)) begin
        bit_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrck_prev    <= 1'b0;
      bit_count    <= '0;
      state        <= ST_IDLE;
      left_sr      <= '0;
      right_sr     <= '0;
      left_word    <= '0;
      pair_word    <= '0;
      pair_pending <= 1'b0;
    end else begin
      pair_pending <= 1'b0;
      if (bit_event) begin
        lrck_prev <= lrck_s2;
        bit_count <= new_count;
      end
      if (abort) begin
        state    <= ST_IDLE;
        left_sr  <= '0;
        right_sr <= '0;
      end else if (frame_edge) begin
        if (lrck_s2) begin
          right_sr <= '0;
        end else begin
          left_sr <= '0;
        end
        case (state)
          ST_IDLE: begin
            if (!lrck_s2) begin
              state <= ST_LEFT;
            end
          end
          ST_LEFT: begin
            if (lrck_s2) begin
              left_word <= left_sr;
              state     <= ST_RIGHT;
            end
          end
          ST_RIGHT: begin
            if (!lrck_s2) begin
              pair_word    <= {left_word, right_sr};
              pair_pending <= 1'b1;
              state        <= ST_LEFT;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (bit_event) begin
        if (lrck_s2) begin
          right_sr <= (right_sr & ~bit_mask) | (bit_mask & {SAMPLE_BITS{sdata_s2}});
        end else begin
          left_sr <= (left_sr & ~bit_mask) | (bit_mask & {SAMPLE_BITS{sdata_s2}});
        end
      end
    end
  end

  assign load_ok = ~out_valid | out_ready;

  // A pair arriving while the previous one is still unconsumed is dropped, never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pair_pending && load_ok) begin
        out_data  <= pair_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (pair_pending && !load_ok) begin
        overflow <= 1'b1;
      end else if (clear_status) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_BCK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_count;
  logic            clock_lost_r;

  assign timeout_hit = ~bit_event & (to_count == TO_W'(TIMEOUT_CYCLES - 1));
  assign clock_lost  = clock_lost_r;

  // Watchdog saturates at TIMEOUT_CYCLES so the abort fires exactly once per outage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_count     <= '0;
      clock_lost_r <= 1'b0;
    end else begin
      if (bit_event) begin
        to_count <= '0;
      end else if (to_count != TO_W'(TIMEOUT_CYCLES)) begin
        to_count <= to_count + TO_W'(1);
      end
      if (timeout_hit) begin
        clock_lost_r <= 1'b1;
      end else if (clear_status) begin
        clock_lost_r <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign clock_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an I2S source with BCK = clk/8 and hand-computed expected pairs.
// Covers the BCK watchdog when I2S_RX_BCK_TIMEOUT_EN is defined.
module tb_i2s_receiver;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        bck;
  logic        lrck;
  logic        sdata;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clear_status;
  logic        clock_lost;

  int vectors;
  int miscompares;

  i2s_receiver #(
    .SAMPLE_BITS    (24),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bck          (bck),
    .lrck         (lrck),
    .sdata        (sdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .clear_status (clear_status),
    .clock_lost   (clock_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no summary, expected completion within 3 ms");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] expected);
    vectors++;
    if (got !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    end
  endtask

  // One BCK period per bit clock; slot bit 0 carries junk (1) to prove it is discarded, bits past 24 too.
  task automatic sendBits(input logic lr, input logic [23:0] word, input int first_k, input int last_k);
    for (int k = first_k; k <= last_k; k++) begin
      bck  = 1'b0;
      lrck = lr;
      if (k >= 1 && k <= 24) sdata = word[24 - k];
      else sdata = 1'b1;
      #40;
      bck = 1'b1;
      #40;
    end
  endtask

  task automatic applyStimulus(input logic [23:0] left, input logic [23:0] right, input int width);
    sendBits(1'b0, left, 0, width - 1);
    sendBits(1'b1, right, 0, width - 1);
  endtask

  task automatic sendTail();
    sendBits(1'b0, 24'h000000, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic restart(input int width);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    sendBits(1'b1, 24'h000000, 0, width - 1);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    enable       = 1'b0;
    bck          = 1'b0;
    lrck         = 1'b0;
    sdata        = 1'b0;
    out_ready    = 1'b0;
    clear_status = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_valid", {47'd0, out_valid}, 48'd0);
    checkOutput("reset_data", out_data, 48'd0);
    checkOutput("reset_overflow", {47'd0, overflow}, 48'd0);
    checkOutput("reset_clock_lost", {47'd0, clock_lost}, 48'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #3;

    $display("[TB] 64 Fs framing");
    restart(32);
    applyStimulus(24'hA5C3F1, 24'h13579B, 32);
    sendTail();
    checkOutput("fs64_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("fs64_data", out_data, 48'hA5C3F1_13579B);
    repeat (20) @(negedge clk);
    checkOutput("fs64_hold_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("fs64_hold_data", out_data, 48'hA5C3F1_13579B);
    handshake();
    checkOutput("fs64_consumed", {47'd0, out_valid}, 48'd0);
    checkOutput("fs64_overflow", {47'd0, overflow}, 48'd0);

    $display("[TB] 48 Fs framing, short slots");
    restart(24);
    applyStimulus(24'hFFFFFF, 24'h123457, 24);
    sendTail();
    checkOutput("fs48_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("fs48_data", out_data, 48'hFFFFFE_123456);
    handshake();

    $display("[TB] overflow with out_ready low");
    restart(32);
    applyStimulus(24'h111111, 24'h222222, 32);
    applyStimulus(24'h333333, 24'h444444, 32);
    repeat (2) @(negedge clk);
    checkOutput("ovf_first_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("ovf_first_data", out_data, 48'h111111_222222);
    checkOutput("ovf_not_yet", {47'd0, overflow}, 48'd0);
    applyStimulus(24'h555555, 24'h666666, 32);
    sendTail();
    checkOutput("ovf_set", {47'd0, overflow}, 48'd1);
    checkOutput("ovf_kept_data", out_data, 48'h111111_222222);
    pulseClear();
    checkOutput("ovf_cleared", {47'd0, overflow}, 48'd0);
    checkOutput("ovf_valid_after_clear", {47'd0, out_valid}, 48'd1);
    handshake();
    checkOutput("ovf_drained", {47'd0, out_valid}, 48'd0);

    $display("[TB] enable dropped mid-left, restored mid-right");
    restart(32);
    sendBits(1'b0, 24'hDEADBE, 0, 9);
    enable = 1'b0;
    sendBits(1'b0, 24'hDEADBE, 10, 31);
    sendBits(1'b1, 24'hC0FFEE, 0, 11);
    enable = 1'b1;
    sendBits(1'b1, 24'hC0FFEE, 12, 31);
    applyStimulus(24'h0A1B2C, 24'h3D4E5F, 32);
    repeat (2) @(negedge clk);
    checkOutput("en_no_pair", {47'd0, out_valid}, 48'd0);
    sendTail();
    checkOutput("en_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("en_data", out_data, 48'h0A1B2C_3D4E5F);

    $display("[TB] asynchronous reset mid-frame");
    fork
      applyStimulus(24'h0F0F0F, 24'hF0F0F0, 32);
      begin
        #1002;
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", {47'd0, out_valid}, 48'd0);
        checkOutput("arst_data", out_data, 48'd0);
        checkOutput("arst_overflow", {47'd0, overflow}, 48'd0);
        #40;
        reset = 1'b0;
      end
    join
    applyStimulus(24'h765432, 24'h89ABCD, 32);
    sendTail();
    checkOutput("arst_pair_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("arst_pair_data", out_data, 48'h765432_89ABCD);
    handshake();

    $display("[TB] BCK stalled for 1100 clk");
    repeat (1000) @(negedge clk);
    checkOutput("stall_early", {47'd0, clock_lost}, 48'd0);
    repeat (100) @(negedge clk);
`ifdef I2S_RX_BCK_TIMEOUT_EN
    checkOutput("stall_lost", {47'd0, clock_lost}, 48'd1);
    sendBits(1'b1, 24'h000000, 0, 31);
`else
    checkOutput("stall_lost_tied", {47'd0, clock_lost}, 48'd0);
    restart(32);
`endif
    applyStimulus(24'h2468AC, 24'hECA864, 32);
    sendTail();
    checkOutput("resume_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("resume_data", out_data, 48'h2468AC_ECA864);
`ifdef I2S_RX_BCK_TIMEOUT_EN
    checkOutput("resume_lost_sticky", {47'd0, clock_lost}, 48'd1);
`endif
    pulseClear();
    checkOutput("resume_lost_clear", {47'd0, clock_lost}, 48'd0);
    handshake();
    checkOutput("resume_drained", {47'd0, out_valid}, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
